// File: rtl/request_registry_if.sv
// Button, clear-strobe and request-status bundle of the elevator request registry.
// The master side drives buttons, strobes and floor; the slave (registry) drives the status.
interface request_registry_if #(
    parameter int LEVELS  = 8,
    parameter int LEVEL_W = 3
);

    logic [LEVELS-1:0]                  btn_in;
    logic [LEVELS-1:0]                  btn_up_out;
    logic [LEVELS-1:0]                  btn_down_out;
    logic [LEVELS-1:0]                  inactivate_in_levels;
    logic [LEVELS-1:0]                  inactivate_out_up_levels;
    logic [LEVELS-1:0]                  inactivate_out_down_levels;
    logic [LEVEL_W-1:0]                 current_level;
    logic [LEVELS-1:0]                  active_in_levels;
    logic [LEVELS-1:0]                  active_out_up_levels;
    logic [LEVELS-1:0]                  active_out_down_levels;
    logic                               req_above;
    logic                               req_below;
    logic                               req_here;
    logic [$clog2(3*LEVELS+1)-1:0]      pending_count;

    modport master (
        output btn_in, btn_up_out, btn_down_out,
        output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
        output current_level,
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
        input  req_above, req_below, req_here, pending_count
    );

    modport slave (
        input  btn_in, btn_up_out, btn_down_out,
        input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
        input  current_level,
        output active_in_levels, active_out_up_levels, active_out_down_levels,
        output req_above, req_below, req_here, pending_count
    );

endinterface

// File: rtl/request_registry.sv
// Elevator request registry: synchronizes raw buttons, latches pending floor requests.
// Define REQUEST_REGISTRY_DEBOUNCE_EN to compile in the per-bit debounce filters.
module request_registry #(
    parameter int LEVELS          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LEVEL_W         = 3
) (
    input logic               clk,
    input logic               reset,
    request_registry_if.slave bus
);

    localparam int NB    = 3 * LEVELS;
    localparam int CNT_W = $clog2(3 * LEVELS + 1);
    // up[LEVELS-1] and down[0] have no physical button, so they are tied off.
    localparam logic [NB-1:0] VALID =
        ~((NB'(1) << (2 * LEVELS - 1)) | (NB'(1) << (2 * LEVELS)));

    if (LEVELS < 2) begin : g_chk_levels
        $error("LEVELS must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LEVEL_W < $clog2(LEVELS)) begin : g_chk_level_w
        $error("LEVEL_W too narrow for LEVELS");
    end

    logic [NB-1:0] raw;
    logic [NB-1:0] clear;
    logic [NB-1:0] filt;
    logic [NB-1:0] rise;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] filt_dly_q;
    logic [NB-1:0] active_q;
    logic [NB-1:0] active_d;

    assign raw   = {bus.btn_down_out, bus.btn_up_out, bus.btn_in} & VALID;
    assign clear = {bus.inactivate_out_down_levels, bus.inactivate_out_up_levels,
                    bus.inactivate_in_levels};

    assign rise     = filt & ~filt_dly_q;
    assign active_d = (active_q | rise) & ~clear;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_dly_q <= '0;
            active_q   <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            filt_dly_q <= filt;
            active_q   <= active_d;
        end
    end

`ifdef REQUEST_REGISTRY_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] cnt_q [NB];
    logic [DB_W-1:0] cnt_d [NB];
    logic [NB-1:0]   filt_q;
    logic [NB-1:0]   filt_d;

    always_comb begin
        filt_d = filt_q;
        for (int j = 0; j < NB; j++) begin
            cnt_d[j] = '0;
            if (sync2_q[j] != filt_q[j]) begin
                if (cnt_q[j] == DB_LAST) begin
                    filt_d[j] = sync2_q[j];
                end else begin
                    cnt_d[j] = cnt_q[j] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the counter array is ordinary state, so each element is reset explicitly.
        if (reset) begin
            for (int j = 0; j < NB; j++) begin
                cnt_q[j] <= '0;
            end
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    logic [LEVELS-1:0] any_pending;
    logic              above_c;
    logic              below_c;
    logic              here_c;
    logic [CNT_W-1:0]  count_c;

    assign any_pending = active_q[LEVELS-1:0] | active_q[2*LEVELS-1:LEVELS]
                       | active_q[3*LEVELS-1:2*LEVELS];

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        above_c = 1'b0;
        below_c = 1'b0;
        here_c  = 1'b0;
        count_c = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (any_pending[i]) begin
                if (i > int'(bus.current_level)) begin
                    above_c = 1'b1;
                end else if (i < int'(bus.current_level)) begin
                    below_c = 1'b1;
                end else begin
                    here_c = 1'b1;
                end
            end
        end
        for (int j = 0; j < NB; j++) begin
            count_c = count_c + CNT_W'(active_q[j]);
        end
    end

    assign bus.active_in_levels       = active_q[LEVELS-1:0];
    assign bus.active_out_up_levels   = active_q[2*LEVELS-1:LEVELS];
    assign bus.active_out_down_levels = active_q[3*LEVELS-1:2*LEVELS];
    assign bus.req_above              = above_c;
    assign bus.req_below              = below_c;
    assign bus.req_here               = here_c;
    assign bus.pending_count          = count_c;

endmodule

// File: tb/tb_request_registry.sv
// Scoreboard bench for request_registry: expected snapshots are queued per edge when
// stimulus is driven and compared once that edge has passed.
module tb_request_registry;

    localparam int LEVELS  = 8;
    localparam int DB      = 4;
    localparam int LEVEL_W = 4;
`ifdef REQUEST_REGISTRY_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    localparam int LAT = DEB_EN ? 3 + DB : 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    request_registry_if #(.LEVELS(LEVELS), .LEVEL_W(LEVEL_W)) bus_if ();

    request_registry #(
        .LEVELS(LEVELS),
        .DEBOUNCE_CYCLES(DB),
        .LEVEL_W(LEVEL_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    typedef struct {
        int         edge_n;
        string      tag;
        logic [7:0] in_v;
        logic [7:0] up_v;
        logic [7:0] down_v;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    // Expected status word {in, up, down, count, above, below, here} from the pending vectors.
    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [3:0] lvl);
        logic [7:0] any;
        logic [7:0] lowmask;
        logic       ab, be, he;
        any = a | b | c;
        if (lvl >= 4'd8) begin
            ab = 1'b0;
            he = 1'b0;
            be = |any;
        end else begin
            lowmask = 8'((16'd1 << lvl) - 16'd1);
            be = |(any & lowmask);
            he = any[lvl[2:0]];
            ab = |(any & ~lowmask & ~(8'd1 << lvl));
        end
        return {a, b, c, 5'($countones({a, b, c})), ab, be, he};
    endfunction

    function automatic logic [31:0] observed();
        return {bus_if.active_in_levels, bus_if.active_out_up_levels,
                bus_if.active_out_down_levels, bus_if.pending_count,
                bus_if.req_above, bus_if.req_below, bus_if.req_here};
    endfunction

    task automatic push(input int e, input string t, input logic [7:0] i,
                        input logic [7:0] u, input logic [7:0] d);
        exp_t x;
        x.edge_n = e;
        x.tag    = t;
        x.in_v   = i;
        x.up_v   = u;
        x.down_v = d;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] hold_in);
        reset                             = 1'b1;
        bus_if.btn_in                     = hold_in;
        bus_if.btn_up_out                 = '0;
        bus_if.btn_down_out               = '0;
        bus_if.inactivate_in_levels       = '0;
        bus_if.inactivate_out_up_levels   = '0;
        bus_if.inactivate_out_down_levels = '0;
        bus_if.current_level              = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] want;
        reset                             = 1'b1;
        bus_if.btn_in                     = 8'hff;
        bus_if.btn_up_out                 = 8'hff;
        bus_if.btn_down_out               = 8'hff;
        bus_if.inactivate_in_levels       = 8'hff;
        bus_if.inactivate_out_up_levels   = 8'h00;
        bus_if.inactivate_out_down_levels = 8'h00;
        bus_if.current_level              = '0;
        for (int k = 1; k <= 3; k++) push(k, "reset_overrides", 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) bus_if.inactivate_in_levels = 8'h00;
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
        end
        apply_reset(8'h00);
    endtask

    task automatic test_latency();
        exp_t        e;
        logic [31:0] want;
        apply_reset(8'h00);
        bus_if.current_level = 4'd1;
        bus_if.btn_in        = 8'h08;
        push(LAT - 1, "in3_before_latency", 8'h00, 8'h00, 8'h00);
        push(LAT,     "in3_set_level1",     8'h08, 8'h00, 8'h00);
        push(LAT + 1, "in3_set_level3",     8'h08, 8'h00, 8'h00);
        push(LAT + 2, "in3_cleared",        8'h00, 8'h00, 8'h00);
        push(16,      "in3_held_no_reset",  8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
            if (k == LAT)     bus_if.current_level        = 4'd3;
            if (k == LAT + 1) bus_if.inactivate_in_levels = 8'h08;
            if (k == LAT + 2) bus_if.inactivate_in_levels = 8'h00;
            if (k == 14)      bus_if.btn_in               = 8'h00;
        end
    endtask

    task automatic test_short_pulse();
        exp_t        e;
        logic [31:0] want;
        for (int p = 0; p < 3; p++) begin
            int         len;
            logic [7:0] v;
            len = DB - 2 + p;
            v   = (!DEB_EN || len >= DB) ? 8'h04 : 8'h00;
            apply_reset(8'h00);
            bus_if.btn_up_out = 8'h04;
            push(LAT, $sformatf("up2_pulse%0d_at_latency", len), 8'h00, v, 8'h00);
            push(12,  $sformatf("up2_pulse%0d_later", len),      8'h00, v, 8'h00);
            for (int k = 1; k <= 12; k++) begin
                tick();
                while (sb.size() != 0 && sb[0].edge_n == k) begin
                    e = sb.pop_front();
                    want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                    compared++;
                    if (observed() !== want) begin
                        mismatched++;
                        $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                    end
                end
                if (k == len) bus_if.btn_up_out = 8'h00;
            end
        end
    endtask

    task automatic test_edge_bits();
        exp_t        e;
        logic [31:0] want;
        apply_reset(8'h00);
        bus_if.btn_up_out   = 8'h81;
        bus_if.btn_down_out = 8'h81;
        push(LAT, "missing_buttons_ignored", 8'h00, 8'h01, 8'h80);
        push(12,  "missing_buttons_later",   8'h00, 8'h01, 8'h80);
        for (int k = 1; k <= 12; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
            if (k == 10) begin
                bus_if.btn_up_out   = 8'h00;
                bus_if.btn_down_out = 8'h00;
            end
        end
    endtask

    task automatic test_priority();
        exp_t        e;
        logic [31:0] want;
        apply_reset(8'h00);
        bus_if.btn_down_out = 8'h20;
        push(LAT,      "down5_clear_wins",     8'h00, 8'h00, 8'h00);
        push(LAT + 1,  "down5_after_clear",    8'h00, 8'h00, 8'h00);
        push(12,       "down5_held_no_reset",  8'h00, 8'h00, 8'h00);
        push(20 + LAT, "down5_repress",        8'h00, 8'h00, 8'h20);
        push(22 + LAT, "down5_before_strobe",  8'h00, 8'h00, 8'h20);
        push(23 + LAT, "down5_cleared",        8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 32; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
            if (k == LAT - 1)  bus_if.inactivate_out_down_levels = 8'h20;
            if (k == LAT)      bus_if.inactivate_out_down_levels = 8'h00;
            if (k == 12)       bus_if.btn_down_out               = 8'h00;
            if (k == 20)       bus_if.btn_down_out               = 8'h20;
            if (k == 22 + LAT) bus_if.inactivate_out_down_levels = 8'h20;
            if (k == 23 + LAT) bus_if.inactivate_out_down_levels = 8'h00;
        end
    endtask

    task automatic test_aggregate();
        exp_t        e;
        logic [31:0] want;
        apply_reset(8'h00);
        bus_if.current_level = 4'd4;
        bus_if.btn_in        = 8'h12;
        bus_if.btn_up_out    = 8'h10;
        bus_if.btn_down_out  = 8'h40;
        push(LAT,     "agg_level4",      8'h12, 8'h10, 8'h40);
        push(LAT + 1, "agg_level12",     8'h12, 8'h10, 8'h40);
        push(LAT + 2, "agg_after_reset", 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
            if (k == LAT) bus_if.current_level = 4'd12;
            if (k == LAT + 1) begin
                reset                = 1'b1;
                bus_if.current_level = 4'd0;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_held_through_reset();
        exp_t        e;
        logic [31:0] want;
        apply_reset(8'h04);
        push(LAT - 1, "in2_held_before_latency", 8'h00, 8'h00, 8'h00);
        push(LAT,     "in2_held_reasserts",      8'h04, 8'h00, 8'h00);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].edge_n == k) begin
                e = sb.pop_front();
                want = model(e.in_v, e.up_v, e.down_v, bus_if.current_level);
                compared++;
                if (observed() !== want) begin
                    mismatched++;
                    $display("FAIL %s @edge %0d: got %h want %h", e.tag, k, observed(), want);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_latency();
        test_short_pulse();
        test_edge_bits();
        test_priority();
        test_aggregate();
        test_held_through_reset();
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drained: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/request_registry.md
REQUEST_REGISTRY -- requirements
Module: request_registry

Interface
REQ-001 SHALL have parameter LEVELS, default 8: number of served floors, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable cycles required before a button change is accepted, minimum 1.
REQ-003 SHALL have parameter LEVEL_W, default 3: current_level width, at least $clog2(LEVELS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports btn_in, btn_up_out, btn_down_out  input  LEVELS each  raw cabin, hall-up and hall-down buttons; asynchronous; bit i is floor i.
REQ-007 SHALL have ports inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels  input  LEVELS each  per-floor clear strobes, synchronous to clk.
REQ-008 SHALL have port current_level  input  LEVEL_W  floor the cabin is at.
REQ-009 SHALL have ports active_in_levels, active_out_up_levels, active_out_down_levels  output  LEVELS each  registered pending requests.
REQ-010 SHALL have ports req_above, req_below, req_here  output  1 each  pending request above, below, or at current_level.
REQ-011 SHALL have port pending_count  output  $clog2(3*LEVELS+1)  total set bits across the three active vectors.

Function
REQ-012 SHALL pass every button bit through a two-flop synchronizer; the second stage is the filter input.
REQ-013 SHALL hold, per bit, a filtered value that changes only at the edge ending DEBOUNCE_CYCLES consecutive cycles in which the synchronized input differed from it; the per-bit counter restarts at 0 on any agreement.
REQ-014 SHALL set an active bit on the edge after its filtered value rises 0->1; a held button SHALL NOT set the bit again after it is cleared.
REQ-015 SHALL clear an active bit on the edge after its inactivate strobe is sampled high.
REQ-016 SHALL give clear priority: a filtered rising edge and an inactivate on the same bit in the same cycle leave the bit 0.
REQ-017 SHALL keep active_out_up_levels[LEVELS-1] and active_out_down_levels[0] constant 0 and ignore those button bits.
REQ-018 SHALL make latency from a stable input rise to active bit high 3+DEBOUNCE_CYCLES edges; inputs stable for fewer than DEBOUNCE_CYCLES cycles after synchronization SHALL be rejected.
REQ-019 SHALL drive req_above, req_below and req_here combinationally from the active registers and current_level: OR of any vector bit at index >, <, == current_level.
REQ-020 SHALL, when current_level >= LEVELS, drive req_here=0 and req_above=0, with req_below equal to any bit pending.
REQ-021 SHALL drive pending_count combinationally as the population count of the three active vectors, maximum 3*LEVELS-2.
REQ-022 SHALL not pipeline the aggregate outputs: they track the active registers in the same cycle.

Reset
REQ-023 SHALL, while reset is high at a clock edge, clear synchronizers, filtered values, counters and active registers to 0, so all outputs read 0 after the edge.
REQ-024 SHALL treat a button held through reset as a new press: it sets its bit 3+DEBOUNCE_CYCLES edges after reset deasserts.
REQ-025 SHALL let reset override button and inactivate inputs in the same cycle.

Configuration
REQ-026 SHALL use macro REQUEST_REGISTRY_DEBOUNCE_EN: when defined, filtering per REQ-013 is compiled in.
REQ-027 SHALL, when REQUEST_REGISTRY_DEBOUNCE_EN is undefined, omit counters and filters: the filtered value equals the synchronizer output, latency is 3 edges, DEBOUNCE_CYCLES is unused, and one-cycle synchronized pulses register.

Verification (LEVELS=8, DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-028 SHALL cover: btn_in[3] high for 10 cycles -> active_in_levels=8'h08 on edge 7; pending_count=1; with current_level=1: req_above=1, req_below=0.
REQ-029 SHALL cover: btn_up_out[2] high for 2 cycles -> no active bit; macro undefined, same stimulus -> active_out_up_levels=8'h04 on edge 3.
REQ-030 SHALL cover: btn_up_out[7] and btn_down_out[0] pressed 10 cycles -> both active vectors stay 8'h00; pending_count=0.
REQ-031 SHALL cover: btn_down_out[5] filtered edge coinciding with inactivate_out_down_levels[5] -> bit 5 stays 0; later inactivate of a set bit clears it one edge after the strobe.
REQ-032 SHALL cover: bits in[1], in[4], up[4], down[6] set, current_level=4 -> req_here=1, req_above=1, req_below=1, pending_count=4; reset pulse -> all outputs 0 the next edge.
REQ-033 SHALL cover: btn_in[2] held high across reset -> active_in_levels[2] reasserts 7 edges after reset deasserts.
